// File: rtl/condicionador_entradas.sv
// Input conditioning for the game circuit: 2-flop synchronizers, per-bit debounce,
// a start pulse and a play FSM that latches the stable switch code once per press.
//
// state       | meaning
// LIVRE       | no key held; waiting for chaves_estaveis to leave 0000
// PRESSIONADO | play captured; waiting for all keys released
module condicionador_entradas #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] chaves_raw,
  input  logic       iniciar_raw,
  output logic [3:0] chaves_estaveis,
  output logic       iniciar_pulso,
  output logic       jogada_pulso,
  output logic [3:0] jogada_codigo,
  output logic       jogada_valida,
  output logic [1:0] db_estado
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LIVRE       = 2'b00,
    PRESSIONADO = 2'b01
  } estado_t;

  logic [4:0]    w_raw;
  logic [4:0]    r_s1;
  logic [4:0]    r_s2;
  logic [4:0]    r_estavel;
  logic [CW-1:0] r_cnt [5];
  logic          r_ini_ant;
  logic          r_ini_pulso;
  estado_t       r_estado;
  estado_t       w_prox;
  logic          w_captura;
  logic          w_one_hot;
  logic          r_jog_pulso;
  logic [3:0]    r_jog_codigo;
  logic          r_jog_valida;

  assign w_raw = {iniciar_raw, chaves_raw};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  // Any return of s2 to the stable level restarts that bit's count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estavel <= '0;
      for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (r_s2[i] == r_estavel[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_estavel[i] <= r_s2[i];
          r_cnt[i]     <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ini_ant   <= 1'b0;
      r_ini_pulso <= 1'b0;
    end else begin
      r_ini_ant   <= r_estavel[4];
      r_ini_pulso <= r_estavel[4] & ~r_ini_ant;
    end
  end

  assign w_one_hot = (r_estavel[3:0] != 4'b0000) &&
                     ((r_estavel[3:0] & (r_estavel[3:0] - 4'd1)) == 4'b0000);

  always_comb begin
    w_prox    = r_estado;
    w_captura = 1'b0;
    case (r_estado)
      LIVRE: begin
        if (r_estavel[3:0] != 4'b0000) begin
          w_prox    = PRESSIONADO;
          w_captura = 1'b1;
        end
      end
      PRESSIONADO: begin
        if (r_estavel[3:0] == 4'b0000) w_prox = LIVRE;
      end
      default: w_prox = LIVRE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado     <= LIVRE;
      r_jog_pulso  <= 1'b0;
      r_jog_codigo <= 4'b0000;
      r_jog_valida <= 1'b0;
    end else begin
      r_estado    <= w_prox;
      r_jog_pulso <= w_captura;
      if (w_captura) begin
        r_jog_codigo <= r_estavel[3:0];
        r_jog_valida <= w_one_hot;
      end
    end
  end

  assign chaves_estaveis = r_estavel[3:0];
  assign iniciar_pulso   = r_ini_pulso;
  assign jogada_pulso    = r_jog_pulso;
  assign jogada_codigo   = r_jog_codigo;
  assign jogada_valida   = r_jog_valida;
  assign db_estado       = r_estado;

endmodule

// File: tb/tb_condicionador_entradas.sv
// Bench for condicionador_entradas: directed scenarios plus random stimulus, all
// checked every cycle against a sliding-window reference model.
module tb_condicionador_entradas;

  localparam int DB = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] chaves_raw;
  logic       iniciar_raw;
  logic [3:0] chaves_estaveis;
  logic       iniciar_pulso;
  logic       jogada_pulso;
  logic [3:0] jogada_codigo;
  logic       jogada_valida;
  logic [1:0] db_estado;

  condicionador_entradas #(.DEBOUNCE_CYCLES(DB)) dut (
    .clock           (clock),
    .reset           (reset),
    .chaves_raw      (chaves_raw),
    .iniciar_raw     (iniciar_raw),
    .chaves_estaveis (chaves_estaveis),
    .iniciar_pulso   (iniciar_pulso),
    .jogada_pulso    (jogada_pulso),
    .jogada_codigo   (jogada_codigo),
    .jogada_valida   (jogada_valida),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int ini_cyc[$];
  int jog_cyc[$];
  logic [3:0] jog_code[$];

  // reference model state
  logic [4:0] m_hist[$];
  logic [4:0] m_stab;
  logic       m_ini_ant;
  logic       m_ini_p;
  logic       m_jog_p;
  logic [3:0] m_code;
  logic       m_valid;
  logic       m_press;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] dut_bus();
    return {3'b000, chaves_estaveis, iniciar_pulso, jogada_pulso,
            jogada_codigo, jogada_valida, db_estado};
  endfunction

  function automatic logic [15:0] model_bus();
    return {3'b000, m_stab[3:0], m_ini_p, m_jog_p, m_code, m_valid, 1'b0, m_press};
  endfunction

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i <= DB; i++) m_hist.push_back(5'b00000);
    m_stab    = '0;
    m_ini_ant = 1'b0;
    m_ini_p   = 1'b0;
    m_jog_p   = 1'b0;
    m_code    = '0;
    m_valid   = 1'b0;
    m_press   = 1'b0;
  endtask

  // A bit's stable level flips once its synchronized copy has differed from it on
  // DB consecutive edges; the synchronized copy lags the raw sample by one edge.
  task automatic model_step(input logic [4:0] raw);
    logic [4:0] nstab;
    logic [3:0] c;
    int         len;
    bit         differs;
    len   = m_hist.size();
    nstab = m_stab;
    for (int b = 0; b < 5; b++) begin
      differs = 1'b1;
      for (int k = 2; k <= DB + 1; k++)
        if (m_hist[len-k][b] == m_stab[b]) differs = 1'b0;
      if (differs) nstab[b] = ~m_stab[b];
    end
    m_ini_p = m_stab[4] & ~m_ini_ant;
    c       = m_stab[3:0];
    m_jog_p = 1'b0;
    if (!m_press && c != 4'b0000) begin
      m_jog_p = 1'b1;
      m_code  = c;
      m_valid = ($countones(c) == 1);
      m_press = 1'b1;
    end else if (m_press && c == 4'b0000) begin
      m_press = 1'b0;
    end
    m_ini_ant = m_stab[4];
    m_stab    = nstab;
    m_hist.push_back(raw);
    if (m_hist.size() > DB + 1) void'(m_hist.pop_front());
  endtask

  task automatic step(input logic [3:0] ch, input logic ini);
    @(negedge clock);
    chaves_raw  = ch;
    iniciar_raw = ini;
    @(posedge clock);
    #1;
    cyc++;
    model_step({ini, ch});
    chk("saidas", dut_bus(), model_bus());
    if (jogada_pulso) begin
      jog_cyc.push_back(cyc);
      jog_code.push_back(jogada_codigo);
    end
    if (iniciar_pulso) ini_cyc.push_back(cyc);
  endtask

  task automatic step_n(input logic [3:0] ch, input logic ini, input int n);
    for (int i = 0; i < n; i++) step(ch, ini);
  endtask

  // Asserted mid-cycle, held across hold+1 edges, released in the high phase.
  task automatic do_reset(input int hold);
    @(negedge clock);
    #2 reset = 1'b1;
    #1 chk("reset_assinc", dut_bus(), 16'h0000);
    model_reset();
    for (int i = 0; i <= hold; i++) begin
      @(posedge clock);
      #1 chk("reset_mantido", dut_bus(), 16'h0000);
    end
    #1 reset = 1'b0;
  endtask

  task automatic clear_logs();
    ini_cyc.delete();
    jog_cyc.delete();
    jog_code.delete();
  endtask

  initial begin
    int k0;
    logic [3:0] v;
    reset       = 1'b1;
    chaves_raw  = 4'b0000;
    iniciar_raw = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1 chk("reset_inicial", dut_bus(), 16'h0000);
    #1 reset = 1'b0;
    step_n(4'b0000, 1'b0, 4);

    // start button held 20 cycles, then a second press
    clear_logs();
    k0 = cyc + 1;
    step_n(4'b0000, 1'b1, 20);
    chk("ini_qtd", 16'(ini_cyc.size()), 16'd1);
    chk("ini_borda", (ini_cyc.size() > 0) ? 16'(ini_cyc[0] - k0) : 16'hffff, 16'd6);
    step_n(4'b0000, 1'b0, 8);
    clear_logs();
    step_n(4'b0000, 1'b1, 10);
    chk("ini_repress", 16'(ini_cyc.size()), 16'd1);
    step_n(4'b0000, 1'b0, 8);

    // bouncing 0010, then held
    clear_logs();
    repeat (2) begin
      step_n(4'b0010, 1'b0, 2);
      step_n(4'b0000, 1'b0, 2);
    end
    chk("bounce_sem_pulso", 16'(jog_cyc.size()), 16'd0);
    step_n(4'b0010, 1'b0, 10);
    chk("bounce_qtd", 16'(jog_cyc.size()), 16'd1);
    chk("bounce_codigo", {12'h000, jogada_codigo}, 16'h0002);
    chk("bounce_valida", {15'h0000, jogada_valida}, 16'h0001);
    chk("bounce_estado", {14'h0000, db_estado}, 16'h0001);
    step_n(4'b0000, 1'b0, 8);
    chk("solto_estado", {14'h0000, db_estado}, 16'h0000);

    // two keys accepted together
    clear_logs();
    step_n(4'b0101, 1'b0, 10);
    chk("duplo_qtd", 16'(jog_cyc.size()), 16'd1);
    chk("duplo_codigo", {12'h000, jogada_codigo}, 16'h0005);
    chk("duplo_valida", {15'h0000, jogada_valida}, 16'h0000);
    step_n(4'b0000, 1'b0, 8);

    // extra key while held is ignored
    clear_logs();
    step_n(4'b0001, 1'b0, 8);
    step_n(4'b1001, 1'b0, 8);
    step_n(4'b0000, 1'b0, 8);
    step_n(4'b1000, 1'b0, 8);
    step_n(4'b0000, 1'b0, 8);
    chk("extra_qtd", 16'(jog_cyc.size()), 16'd2);
    chk("extra_cod0", (jog_code.size() > 0) ? {12'h000, jog_code[0]} : 16'hffff, 16'h0001);
    chk("extra_cod1", (jog_code.size() > 1) ? {12'h000, jog_code[1]} : 16'hffff, 16'h0008);

    // reset while a key is held and accepted
    step_n(4'b0100, 1'b0, 8);
    chk("pre_reset_estado", {14'h0000, db_estado}, 16'h0001);
    do_reset(2);
    clear_logs();
    k0 = cyc + 1;
    step_n(4'b0100, 1'b0, 10);
    chk("pos_reset_qtd", 16'(jog_cyc.size()), 16'd1);
    chk("pos_reset_cod", (jog_code.size() > 0) ? {12'h000, jog_code[0]} : 16'hffff, 16'h0004);
    chk("pos_reset_borda", (jog_cyc.size() > 0) ? 16'(jog_cyc[0] - k0) : 16'hffff, 16'd6);
    step_n(4'b0000, 1'b0, 8);

    // random segments with occasional resets
    repeat (250) begin
      if ($urandom_range(0, 99) < 4) begin
        do_reset($urandom_range(0, 3));
      end else begin
        case ($urandom_range(0, 3))
          0:       v = 4'b0000;
          1:       v = 4'b0001 << $urandom_range(0, 3);
          default: v = 4'($urandom_range(0, 15));
        endcase
        step_n(v, 1'($urandom_range(0, 1)), $urandom_range(1, 9));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/condicionador_entradas.md
Name: condicionador_entradas

Overview:
Input-conditioning stage placed directly upstream of the game circuit. It synchronizes and debounces the raw board inputs `chaves[3:0]` and `iniciar`. It delivers clean, single-cycle events to the circuit: a start pulse and a play pulse, plus the stable switch code latched with the play pulse. This replaces raw switch and button wiring into the game circuit's `iniciar` and `chaves` inputs.

Parameters:
- DEBOUNCE_CYCLES, default 50000. Consecutive stable cycles needed to accept a new input level. Minimum 2; the bench uses 4.

Ports:
- clock, input, 1. System clock; all state updates on its rising edge.
- reset, input, 1. Asynchronous, active-high. Clears all state.
- chaves_raw, input, 4. Raw switch or button levels; asynchronous, may bounce.
- iniciar_raw, input, 1. Raw start button; asynchronous, may bounce.
- chaves_estaveis, output, 4. Debounced switch levels.
- iniciar_pulso, output, 1. One-cycle pulse on each accepted rising edge of iniciar.
- jogada_pulso, output, 1. One-cycle pulse when a play is accepted.
- jogada_codigo, output, 4. Debounced switch code captured with the last jogada_pulso; held until the next one.
- jogada_valida, output, 1. Set when the captured code is one-hot; updated together with jogada_codigo.
- db_estado, output, 2. Play FSM state encoding, for the 7-seg debug display.

Behaviour:
- Reset (asynchronous, reset=1):
  - All synchronizer flops, debounce counters, stable values, pulse registers, jogada_codigo, jogada_valida and the FSM clear to 0.
  - The FSM goes to LIVRE.
  - All outputs are 0 while reset is held and in the first cycle after release.
- Synchronizer: each of the 5 raw bits passes through 2 flip-flops (s1, s2). Edge e0 is the first edge at which s1 samples a new raw level.
- Debounce, independent per bit, 5 counters, each ceil(log2(DEBOUNCE_CYCLES)) bits wide:
  - If s2 == stable: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= s2 and counter <= 0.
  - Else: counter <= counter+1.
  - A clean level change therefore updates stable at edge e0+DEBOUNCE_CYCLES+1.
  - Any bounce that returns s2 to the stable value restarts the count.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never alters stable.
- chaves_estaveis equals the stable value of the 4 chaves bits. It changes at e0+DEBOUNCE_CYCLES+1.
- iniciar_pulso:
  - Registered. It is 1 for exactly one cycle, starting at the edge after stable iniciar goes 0->1, i.e. e0+DEBOUNCE_CYCLES+2.
  - Holding the button produces no further pulses.
  - A release followed by a new press produces a new pulse.
- Play FSM (db_estado: LIVRE=00, PRESSIONADO=01, 10/11 unused and recover to LIVRE):
  - LIVRE: if chaves_estaveis != 0000, then next state is PRESSIONADO. In the same edge, jogada_pulso <= 1, jogada_codigo <= chaves_estaveis, and jogada_valida <= (exactly one bit set).
  - PRESSIONADO: stays until chaves_estaveis == 0000, then returns to LIVRE. No pulse is produced in this state, and extra keys pressed while held are ignored.
  - jogada_pulso is 1 for exactly one cycle: the edge after chaves_estaveis leaves 0000.
- Simultaneous events:
  - Several chaves bits accepted in the same cycle produce a single pulse. The code holds all the bits and jogada_valida=0.
  - Bits accepted in different cycles: only the first nonzero value is captured.
  - iniciar_pulso and jogada_pulso are independent and may coincide.
- Reset mid-count or mid-press: state clears immediately and no pulse is emitted. After release, an input still held is debounced afresh from stable=0. It is therefore accepted DEBOUNCE_CYCLES+2 edges after release and produces a pulse as if newly pressed.
- No combinational path from any input to any output.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset asserted asynchronously mid-cycle -> all outputs 0 before the next clock edge; db_estado=00.
2. iniciar_raw rises cleanly at e0 and is held 20 cycles -> chaves_estaveis stays 0000; iniciar_pulso=1 for exactly one cycle, starting at edge e0+6, and never again while held.
3. chaves_raw=0010 with bounce (toggles 0010/0000 every 2 cycles for 8 cycles), then held -> no pulse during bounce. Once steady 0010 is accepted: jogada_pulso for one cycle, jogada_codigo=0010, jogada_valida=1, db_estado=01. After release for ≥6 cycles -> db_estado=00.
4. chaves_raw=0101 applied in one cycle -> a single jogada_pulso, jogada_codigo=0101, jogada_valida=0.
5. Press 0001, then add 1000 while held, then release to 0000, then press 1000 -> exactly two pulses, with codes 0001 and then 1000.
6. Reset pulse while 0100 is held and accepted (db_estado=01), keeping 0100 held -> outputs clear. Then jogada_pulso once with code 0100, 6 edges after reset release.
